// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } ctrl_state_e;

    localparam logic REDIRECT_TRAP = 1'b1;
    localparam logic REDIRECT_MRET = 1'b0;

    localparam int unsigned MD_LATENCY_DEF   = 4;
    localparam int unsigned FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode operands and a load in EX.
module hazard_detect (
    input  logic       ex_load,
    input  logic       ex_wr_reg,
    input  logic [4:0] ex_wr_regindex,
    input  logic [4:0] de_rs1addr,
    input  logic [4:0] de_rs2addr,
    input  logic       de_rs1_used,
    input  logic       de_rs2_used,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = de_rs1_used && (de_rs1addr == ex_wr_regindex);
        rs2_hit  = de_rs2_used && (de_rs2addr == ex_wr_regindex);
        // x0 is never a real producer, so a load to x0 cannot create a hazard
        load_use = ex_load && ex_wr_reg && (ex_wr_regindex != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/DE and DE/EX pipeline registers.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY   = MD_LATENCY_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       cpurst_n,
    input  logic [4:0] de_rs1addr,
    input  logic [4:0] de_rs2addr,
    input  logic       de_rs1_used,
    input  logic       de_rs2_used,
    input  logic       ex_load,
    input  logic       ex_wr_reg,
    input  logic [4:0] ex_wr_regindex,
    input  logic       ex_md_op,
    input  logic       ex_mret,
    input  logic       exe_store_load_conflict,
    input  logic       mem_stall,
    input  logic       readram_stall,
    input  logic       mem2wb_exp,
    input  logic       interrupt,
    output logic       de_ex_hold,
    output logic       de_ex_flush,
    output logic       if_de_hold,
    output logic       if_de_flush,
    output logic       mult_stall,
    output logic       md_done,
    output logic       redirect_valid,
    output logic       redirect_sel
);

    ctrl_state_e state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [1:0]  fl_cnt_q, fl_cnt_d;

    logic load_use;
    logic ext_stall;
    logic trap;
    logic flush_req;

    logic deh_c, def_c, idh_c, idf_c, ms_c, done_c, rv_c, rs_c;

    hazard_detect u_hazard_detect (
        .ex_load        (ex_load),
        .ex_wr_reg      (ex_wr_reg),
        .ex_wr_regindex (ex_wr_regindex),
        .de_rs1addr     (de_rs1addr),
        .de_rs2addr     (de_rs2addr),
        .de_rs1_used    (de_rs1_used),
        .de_rs2_used    (de_rs2_used),
        .load_use       (load_use)
    );

    always_comb begin
        ext_stall = exe_store_load_conflict || mem_stall || readram_stall;
        trap      = mem2wb_exp || interrupt;
        flush_req = trap || ex_mret;
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        fl_cnt_d = fl_cnt_q;
        deh_c    = 1'b0;
        def_c    = 1'b0;
        idh_c    = 1'b0;
        idf_c    = 1'b0;
        ms_c     = 1'b0;
        done_c   = 1'b0;
        rv_c     = 1'b0;
        rs_c     = trap ? REDIRECT_TRAP : REDIRECT_MRET;

        if (flush_req) begin
            // Abort any mul/div in flight; the redirect restarts the stream
            def_c    = 1'b1;
            idf_c    = 1'b1;
            rv_c     = 1'b1;
            state_d  = ST_FLUSH;
            fl_cnt_d = 2'(FLUSH_CYCLES - 1);
            md_cnt_d = '0;
        end else if (state_q == ST_FLUSH) begin
            def_c = 1'b1;
            idf_c = 1'b1;
            if (fl_cnt_q == 2'd0) begin
                state_d = ST_RUN;
            end else begin
                fl_cnt_d = fl_cnt_q - 2'd1;
            end
        end else if (ext_stall) begin
            deh_c = 1'b1;
            idh_c = 1'b1;
            ms_c  = (state_q == ST_MD_BUSY);
        end else if (state_q == ST_MD_BUSY) begin
            ms_c  = 1'b1;
            deh_c = 1'b1;
            idh_c = 1'b1;
            if (md_cnt_q == 4'd0) begin
                done_c  = 1'b1;
                state_d = ST_RUN;
            end else begin
                md_cnt_d = md_cnt_q - 4'd1;
            end
        end else if (state_q == ST_RUN) begin
            if (ex_md_op) begin
                ms_c     = 1'b1;
                deh_c    = 1'b1;
                idh_c    = 1'b1;
                md_cnt_d = 4'(MD_LATENCY - 2);
                state_d  = ST_MD_BUSY;
            end else if (load_use) begin
                def_c = 1'b1;
                idh_c = 1'b1;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Outputs are combinational, so they are forced low while reset is held
    always_comb begin
        de_ex_hold     = deh_c  && cpurst_n;
        de_ex_flush    = def_c  && cpurst_n;
        if_de_hold     = idh_c  && cpurst_n;
        if_de_flush    = idf_c  && cpurst_n;
        mult_stall     = ms_c   && cpurst_n;
        md_done        = done_c && cpurst_n;
        redirect_valid = rv_c   && cpurst_n;
        redirect_sel   = rs_c   && cpurst_n;
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

endmodule
